apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
- Shares the single APB master port between two requesters, m0 (host) and m1 (DMA/test sequencer), using round-robin arbitration.
- Sequences each granted request through APB SETUP and ACCESS phases.
- Decodes the address into a one-hot psel: bit0 = GPIO, bit1 = UART.
- Waits for pready, with a timeout, then returns read data and status to the winning requester.

Parameters:
- GPIO_BASE, 24'h000000, value of pAdd[31:8] that selects the GPIO slave (psel = 2'b01).
- UART_BASE, 24'h000001, value of pAdd[31:8] that selects the UART slave (psel = 2'b10).
- TIMEOUT, 16, maximum ACCESS cycles to wait for pready before aborting; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  requester 0 transfer request; held high until m0_done.
- m0_wr  in  1  1 = write, 0 = read; stable while m0_req is high.
- m0_addr  in  32  requester 0 address.
- m0_wdata  in  32  requester 0 write data.
- m0_done  out  1  one-cycle completion pulse to requester 0.
- m0_err  out  1  valid with m0_done: decode error or timeout.
- m1_req, m1_wr, m1_addr, m1_wdata, m1_done, m1_err: same as m0_* for requester 1.
- rdata  out  32  read data; valid in the cycle m0_done or m1_done pulses.
- pAdd  out  32  APB address.
- pwData  out  32  APB write data.
- pwr  out  1  APB write strobe (1 = write).
- psel  out  2  one-hot slave select.
- pen  out  1  APB enable (ACCESS phase).
- prdata  in  32  APB read data.
- pready  in  1  slave ready.

Behaviour:
- Reset: state IDLE. pAdd, pwData, rdata = 0. pwr, pen, m*_done, m*_err = 0. psel = 2'b00. Round-robin pointer last = 1, so m0 wins first.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE, no request: stay in IDLE; all bus outputs hold their previous values except psel = 0 and pen = 0.
- IDLE, one or more requests:
  - Both requesting: grant the one not equal to last. Otherwise grant the single requester.
  - Register the grant id and latch the winner's addr, wdata and wr into pAdd, pwData and pwr.
  - Address decode on addr[31:8]:
    - matches GPIO_BASE: psel = 01, go to SETUP.
    - matches UART_BASE: psel = 10, go to SETUP.
    - no match: psel stays 00, set err, go to DONE (no bus cycle is issued).
- SETUP: exactly one cycle with psel asserted and pen = 0. Next state is ACCESS.
- ACCESS:
  - pen = 1; psel, pAdd, pwData and pwr held stable.
  - Wait counter starts at 0 and increments each ACCESS cycle with pready = 0.
  - pready = 1: capture prdata into rdata if it is a read (rdata unchanged on a write). Clear err, go to DONE.
  - Counter reaches TIMEOUT-1 with pready still 0: set err, leave rdata unchanged, go to DONE.
- DONE:
  - psel = 0, pen = 0.
  - Pulse done and err for the granted requester only, for exactly one cycle.
  - Update last to the granted id. Next state is IDLE.
- Latency, zero wait states: the request seen in IDLE gives SETUP at +1, ACCESS at +2 with pready, done at +3. Back-to-back transfers therefore take 4 cycles each.
- Requester dropping req mid-transfer: the transfer still completes and done is still pulsed.
- A requester sampled high in the IDLE cycle right after its own done starts a new transfer. Requesters must drop req on done.
- Simultaneous requests arriving in IDLE: arbitration is decided in that same cycle; the loser waits and is granted next, provided it keeps req high.
- pready asserted during SETUP: ignored.
- Reset asserted mid-transfer: immediate return to reset values. No done pulse; the transfer is lost.

Decomposition:
- Shared package apb_pkg:
  - state encoding (IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, DONE = 2'd3);
  - PSEL_GPIO = 2'b01, PSEL_UART = 2'b10;
  - default base constants.
- One sub-module, apb_rr_arbiter2:
  - inputs: req[1:0], last, enable;
  - outputs: gnt_id and gnt_valid, combinational.
- The FSM, address decode, timeout counter and bus registers stay in the top module.

Test Plan:
- Reset then m0 write to addr 32'h00000104, wdata 32'hA5, pready tied 1 -> SETUP cycle with psel = 10, pen = 0, pwr = 1, pAdd = 32'h104; next cycle pen = 1; m0_done pulses 3 cycles after req, with m0_err = 0.
- m1 read of 32'h00000008, pready held 0 for 3 ACCESS cycles, prdata = 32'hDEADBEEF -> psel = 01; pen high for 4 cycles; rdata = DEADBEEF with m1_done; m1_err = 0.
- m0 and m1 request in the same cycle, both held -> m0 is served first, then m1; repeating the pair gives m1 first next time only if last = 0 (alternation check over 4 transfers: order 0,1,0,1).
- Read of 32'h00001000 (unmapped) -> psel never leaves 00 and pen is never 1; done and err pulse 1 cycle after IDLE sees req.
- UART read with pready stuck 0, TIMEOUT = 16 -> pen high exactly 16 cycles; then err = 1, rdata unchanged, bus idle.
- rst asserted during ACCESS -> pen, psel and pwr are 0 immediately (asynchronous) and no done pulse occurs; the next request after reset release gets a normal 4-cycle transfer.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the two-requester APB master: widths, state encoding,
// slave selects, default address map and the request payload.
package apb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BASE_W = 24;
  localparam int unsigned CNT_W  = 8;

  localparam logic [BASE_W-1:0] GPIO_BASE_DEF = 24'h000000;
  localparam logic [BASE_W-1:0] UART_BASE_DEF = 24'h000001;
  localparam int unsigned       TIMEOUT_DEF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } apb_state_e;

  localparam logic [1:0] PSEL_NONE = 2'b00;
  localparam logic [1:0] PSEL_GPIO = 2'b01;
  localparam logic [1:0] PSEL_UART = 2'b10;

  // One requester's transfer description.
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } apb_req_t;

  // Map the upper address bits onto a one-hot slave select (zero = unmapped).
  function automatic logic [1:0] decode_psel(input logic [BASE_W-1:0] page,
                                             input logic [BASE_W-1:0] gpio_base,
                                             input logic [BASE_W-1:0] uart_base);
    logic [1:0] sel;
    sel = PSEL_NONE;
    if (page == gpio_base) begin
      sel = PSEL_GPIO;
    end else if (page == uart_base) begin
      sel = PSEL_UART;
    end
    return sel;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester that was not served last wins.
module apb_rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       enable_i,
  output logic       gnt_id_o,
  output logic       gnt_valid_o
);

  // Combinational grant decision.
  always_comb begin
    gnt_valid_o = enable_i & (|req_i);
    gnt_id_o    = 1'b0;
    if (req_i == 2'b11) begin
      gnt_id_o = ~last_i;
    end else begin
      gnt_id_o = req_i[1];
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by two requesters: round-robin arbitration, address decode,
// SETUP/ACCESS sequencing with a pready timeout, and per-requester completion.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter logic [BASE_W-1:0] GPIO_BASE = GPIO_BASE_DEF,
  parameter logic [BASE_W-1:0] UART_BASE = UART_BASE_DEF,
  parameter int unsigned       TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_done,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_done,
  output logic              m1_err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] pAdd,
  output logic [DATA_W-1:0] pwData,
  output logic              pwr,
  output logic [1:0]        psel,
  output logic              pen,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  apb_state_e        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] padd_q, padd_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwr_q, pwr_d;
  logic [1:0]        psel_q, psel_d;
  logic              pen_q, pen_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;

  logic              gnt_id;
  logic              gnt_valid;
  apb_req_t          m0_r, m1_r, win_r;
  logic [1:0]        dec_sel;

  assign m0_r    = {m0_wr, m0_addr, m0_wdata};
  assign m1_r    = {m1_wr, m1_addr, m1_wdata};
  assign win_r   = gnt_id ? m1_r : m0_r;
  assign dec_sel = decode_psel(win_r.addr[ADDR_W-1:ADDR_W-BASE_W], GPIO_BASE, UART_BASE);

  // Grant is only taken while the bus is idle.
  apb_rr_arbiter2 u_arb (
    .req_i       ({m1_req, m0_req}),
    .last_i      (last_q),
    .enable_i    (state_q == ST_IDLE),
    .gnt_id_o    (gnt_id),
    .gnt_valid_o (gnt_valid)
  );

  // Next-state and next-output logic; done/err default low so they pulse once.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    padd_d   = padd_q;
    pwdata_d = pwdata_q;
    pwr_d    = pwr_q;
    psel_d   = psel_q;
    pen_d    = pen_q;
    rdata_d  = rdata_q;
    done_d   = 2'b00;
    err_d    = 2'b00;

    unique case (state_q)
      ST_IDLE: begin
        psel_d = PSEL_NONE;
        pen_d  = 1'b0;
        if (gnt_valid) begin
          gnt_d    = gnt_id;
          padd_d   = win_r.addr;
          pwdata_d = win_r.wdata;
          pwr_d    = win_r.wr;
          psel_d   = dec_sel;
          cnt_d    = '0;
          if (dec_sel == PSEL_NONE) begin
            // Unmapped address: complete with error without touching the bus.
            done_d[gnt_id] = 1'b1;
            err_d[gnt_id]  = 1'b1;
            state_d        = ST_DONE;
          end else begin
            state_d = ST_SETUP;
          end
        end
      end

      ST_SETUP: begin
        pen_d   = 1'b1;
        state_d = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (pready) begin
          if (!pwr_q) begin
            rdata_d = prdata;
          end
          done_d[gnt_q] = 1'b1;
          psel_d        = PSEL_NONE;
          pen_d         = 1'b0;
          state_d       = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          done_d[gnt_q] = 1'b1;
          err_d[gnt_q]  = 1'b1;
          psel_d        = PSEL_NONE;
          pen_d         = 1'b0;
          state_d       = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        psel_d  = PSEL_NONE;
        pen_d   = 1'b0;
        last_d  = gnt_q;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and bus registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      padd_q   <= '0;
      pwdata_q <= '0;
      pwr_q    <= 1'b0;
      psel_q   <= PSEL_NONE;
      pen_q    <= 1'b0;
      rdata_q  <= '0;
      done_q   <= 2'b00;
      err_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      padd_q   <= padd_d;
      pwdata_q <= pwdata_d;
      pwr_q    <= pwr_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign pAdd    = padd_q;
  assign pwData  = pwdata_q;
  assign pwr     = pwr_q;
  assign psel    = psel_q;
  assign pen     = pen_q;
  assign rdata   = rdata_q;
  assign m0_done = done_q[0];
  assign m0_err  = err_q[0];
  assign m1_done = done_q[1];
  assign m1_err  = err_q[1];

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed and random transfers compared against
// a transaction-level model of arbitration order, latency, error and read data.
module tb_apb_master_arbiter;

  localparam int unsigned TO = 16;

  logic        clk, rst;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_done, m0_err, m1_done, m1_err;
  logic [31:0] rdata, pAdd, pwData, prdata;
  logic        pwr, pen, pready;
  logic [1:0]  psel;

  int          checks;
  int          errors;
  logic        last_m;
  logic [31:0] rdata_m;

  apb_master_arbiter #(
    .GPIO_BASE (24'h000000),
    .UART_BASE (24'h000001),
    .TIMEOUT   (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_req   (m0_req),
    .m0_wr    (m0_wr),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_done  (m0_done),
    .m0_err   (m0_err),
    .m1_req   (m1_req),
    .m1_wr    (m1_wr),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_done  (m1_done),
    .m1_err   (m1_err),
    .rdata    (rdata),
    .pAdd     (pAdd),
    .pwData   (pwData),
    .pwr      (pwr),
    .psel     (psel),
    .pen      (pen),
    .prdata   (prdata),
    .pready   (pready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Address map: page 0 is GPIO, page 1 is UART, everything else unmapped.
  function automatic logic [1:0] exp_psel(input logic [31:0] a);
    if (a[31:8] == 24'h000000) return 2'b01;
    if (a[31:8] == 24'h000001) return 2'b10;
    return 2'b00;
  endfunction

  // Number of cycles pen stays high for a given slave wait count.
  function automatic int pen_cycles(input logic [31:0] a, input int waits);
    if (exp_psel(a) == 2'b00) return 0;
    return (waits + 1 < int'(TO)) ? waits + 1 : int'(TO);
  endfunction

  // Cycles from the IDLE edge that samples req to the visible done pulse.
  function automatic int latency(input logic [31:0] a, input int waits);
    if (exp_psel(a) == 2'b00) return 1;
    return 2 + pen_cycles(a, waits);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int kind;
    kind = $urandom_range(0, 2);
    a = $urandom;
    if (kind == 0) a[31:8] = 24'h000000;
    else if (kind == 1) a[31:8] = 24'h000001;
    else if (a[31:8] < 24'h000002) a[31:8] = 24'h000100;
    return a;
  endfunction

  // Run one or two requesters to completion and compare every completion
  // against the model's order, timing, error, read data and bus activity.
  task automatic run(input logic [1:0] mask, input logic [1:0] wr,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input logic [31:0] w0, input logic [31:0] w1,
                     input logic [31:0] p0, input logic [31:0] p1,
                     input int waits, input bit drop_early);
    int          ord[$];
    logic [31:0] a[2];
    logic [31:0] w[2];
    logic [31:0] p[2];
    int          c, k, id, t_exp, pen_cnt, bad;
    logic [1:0]  psel_seen, pexp, err_exp;
    bit          setup_seen, e_err;
    a[0] = a0; a[1] = a1; w[0] = w0; w[1] = w1; p[0] = p0; p[1] = p1;
    if (mask == 2'b11) begin
      if (last_m) begin ord.push_back(0); ord.push_back(1); end
      else begin ord.push_back(1); ord.push_back(0); end
    end else if (mask[1]) begin
      ord.push_back(1);
    end else begin
      ord.push_back(0);
    end
    m0_req = mask[0]; m0_wr = wr[0]; m0_addr = a0; m0_wdata = w0;
    m1_req = mask[1]; m1_wr = wr[1]; m1_addr = a1; m1_wdata = w1;
    prdata = p[ord[0]];
    pready = 1'b1;
    t_exp = latency(a[ord[0]], waits);
    c = 0; k = 0; pen_cnt = 0; bad = 0; psel_seen = 2'b00; setup_seen = 1'b0;
    while (k < ord.size() && c < 300) begin
      step();
      c++;
      id   = ord[k];
      pexp = exp_psel(a[id]);
      psel_seen = psel_seen | psel;
      if (pen === 1'b1 && psel !== pexp) bad++;
      if (pen === 1'b0 && psel !== 2'b00 && !setup_seen) begin
        setup_seen = 1'b1;
        chk("setup_paddr", pAdd, a[id]);
        chk("setup_pwdata", pwData, w[id]);
        chk("setup_pwr", 32'(pwr), 32'(wr[id]));
        chk("setup_psel", 32'(psel), 32'(pexp));
      end
      if (pen === 1'b1) begin
        pready = (pen_cnt >= waits);
        pen_cnt++;
        if (drop_early) begin
          if (id == 0) m0_req = 1'b0; else m1_req = 1'b0;
        end
      end else begin
        pready = 1'b1;
      end
      if (m0_done === 1'b1 || m1_done === 1'b1) begin
        e_err   = (pexp == 2'b00) || (waits >= int'(TO));
        err_exp = e_err ? ((id == 1) ? 2'b10 : 2'b01) : 2'b00;
        if (!e_err && !wr[id]) rdata_m = p[id];
        chk("done_id", 32'({m1_done, m0_done}), (id == 1) ? 32'd2 : 32'd1);
        chk("done_cycle", 32'(c), 32'(t_exp));
        chk("err", 32'({m1_err, m0_err}), 32'(err_exp));
        chk("rdata", rdata, rdata_m);
        chk("pen_cycles", 32'(pen_cnt), 32'(pen_cycles(a[id], waits)));
        chk("psel_seen", 32'(psel_seen), 32'(pexp));
        chk("pen_psel_stable", 32'(bad), 32'd0);
        if (id == 0) m0_req = 1'b0; else m1_req = 1'b0;
        last_m = id[0];
        k++;
        if (k < ord.size()) begin
          pen_cnt = 0; bad = 0; psel_seen = 2'b00; setup_seen = 1'b0;
          prdata = p[ord[k]];
          t_exp = c + 1 + latency(a[ord[k]], waits);
        end
      end
    end
    chk("all_done", 32'(k), 32'(ord.size()));
    step();
    chk("done_one_cycle", 32'({m1_done, m0_done, m1_err, m0_err}), 32'd0);
    chk("bus_idle", 32'({psel, pen}), 32'd0);
    m0_req = 1'b0; m1_req = 1'b0; pready = 1'b1;
  endtask

  initial begin
    logic [1:0]  mask, wr;
    int          waits;
    bit          drop;
    checks = 0; errors = 0;
    clk = 1'b0; rst = 1'b1;
    m0_req = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_wdata = '0;
    prdata = '0; pready = 1'b1;
    last_m = 1'b1; rdata_m = '0;

    // Reset values.
    step(); step();
    chk("rst_paddr", pAdd, 32'd0);
    chk("rst_pwdata", pwData, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ctrl", 32'({pwr, pen, psel}), 32'd0);
    chk("rst_done_err", 32'({m1_done, m0_done, m1_err, m0_err}), 32'd0);
    rst = 1'b0;
    step();

    // m0 write to UART, zero wait states.
    run(2'b01, 2'b01, 32'h0000_0104, 32'h0, 32'hA5, 32'h0, 32'h0, 32'h0, 0, 1'b0);
    // m1 read from GPIO with three wait states.
    run(2'b10, 2'b00, 32'h0, 32'h0000_0008, 32'h0, 32'h1111, 32'h0, 32'hDEAD_BEEF, 3, 1'b0);
    // Simultaneous requests, twice: order 0,1,0,1.
    run(2'b11, 2'b11, 32'h0000_0010, 32'h0000_0120, 32'h1, 32'h2, 32'h0, 32'h0, 0, 1'b0);
    run(2'b11, 2'b00, 32'h0000_0020, 32'h0000_0130, 32'h3, 32'h4, 32'h5555_0000, 32'h0000_AAAA, 1, 1'b0);
    // Unmapped read.
    run(2'b01, 2'b00, 32'h0000_1000, 32'h0, 32'h0, 32'h0, 32'h1234_5678, 32'h0, 0, 1'b0);
    // UART read timing out.
    run(2'b10, 2'b00, 32'h0, 32'h0000_0140, 32'h0, 32'h0, 32'h0, 32'hCAFE_F00D, 255, 1'b0);
    // Requester dropping req during ACCESS.
    run(2'b01, 2'b00, 32'h0000_0044, 32'h0, 32'h0, 32'h0, 32'h0BAD_CAFE, 32'h0, 2, 1'b1);

    // Reset during ACCESS of a write.
    m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 32'h0000_0104; m1_wdata = 32'h77; pready = 1'b0;
    step(); step();
    chk("pre_rst_pen", 32'({pen, pwr}), 32'd3);
    rst = 1'b1;
    #1;
    chk("async_rst_bus", 32'({pen, psel, pwr}), 32'd0);
    m1_req = 1'b0; pready = 1'b1;
    step();
    chk("rst_no_done", 32'({m1_done, m0_done}), 32'd0);
    rst = 1'b0;
    last_m = 1'b1; rdata_m = '0;
    step();
    chk("post_rst_no_done", 32'({m1_done, m0_done}), 32'd0);
    run(2'b01, 2'b00, 32'h0000_0008, 32'h0, 32'h0, 32'h0, 32'h0F0F_0F0F, 32'h0, 0, 1'b0);

    // Random transfers.
    for (int i = 0; i < 30; i++) begin
      mask  = 2'($urandom_range(1, 3));
      wr    = 2'($urandom_range(0, 3));
      waits = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 4));
      drop  = (mask != 2'b11) && ($urandom_range(0, 3) == 0);
      run(mask, wr, rand_addr(), rand_addr(), $urandom, $urandom, $urandom, $urandom, waits, drop);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
